// File: rtl/vga_ctrl_pkg.sv
// vga_ctrl_pkg: 640x480@60 timing constants and the shared colour type
package vga_ctrl_pkg;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CNT_W    = 10;
   typedef logic [23:0] rgb24_t;
endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: wrapping position counter with active/sync region decode for one axis
module vga_axis_cnt import vga_ctrl_pkg::*; #(
   parameter int ACTIVE = H_ACTIVE,
   parameter int FP     = H_FP,
   parameter int SYNC   = H_SYNC,
   parameter int BP     = H_BP
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_step,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last,
   output logic             o_active,
   output logic             o_sync_n
);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
   localparam logic [CNT_W-1:0] C_ACT  = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] C_SS   = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] C_SE   = CNT_W'(ACTIVE + FP + SYNC);

   logic [CNT_W-1:0] r_cnt;

   assign o_cnt    = r_cnt;
   assign o_last   = r_cnt == C_LAST;
   assign o_active = r_cnt < C_ACT;
   assign o_sync_n = !((r_cnt >= C_SS) && (r_cnt < C_SE));

   // Advance on each step, wrapping to zero after the last position of the axis
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= '0;
      else if (i_step) r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator issuing pixel coordinates and registering colour/syncs to the DAC
module vga_ctrl import vga_ctrl_pkg::*; #(
   parameter int H_ACTIVE = vga_ctrl_pkg::H_ACTIVE,
   parameter int H_FP     = vga_ctrl_pkg::H_FP,
   parameter int H_SYNC   = vga_ctrl_pkg::H_SYNC,
   parameter int H_BP     = vga_ctrl_pkg::H_BP,
   parameter int V_ACTIVE = vga_ctrl_pkg::V_ACTIVE,
   parameter int V_FP     = vga_ctrl_pkg::V_FP,
   parameter int V_SYNC   = vga_ctrl_pkg::V_SYNC,
   parameter int V_BP     = vga_ctrl_pkg::V_BP
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   output logic [9:0]  o_x,
   output logic [8:0]  o_y,
   input  logic [23:0] i_rgb,
   output logic [7:0]  o_vga_r,
   output logic [7:0]  o_vga_g,
   output logic [7:0]  o_vga_b,
   output logic        o_vga_hs,
   output logic        o_vga_vs,
   output logic        o_vga_blank_n,
   output logic        o_vga_sync_n,
   output logic        o_frame_start
);
   logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
   logic             w_h_last, w_v_last, w_h_act, w_v_act, w_hs0, w_vs0, w_active;
   rgb24_t           r_rgb;
   logic             r_blank_n, r_hs, r_vs;

   vga_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(i_en),
      .o_cnt(w_h_cnt), .o_last(w_h_last), .o_active(w_h_act), .o_sync_n(w_hs0));

   // The vertical axis steps once per line, on the cycle the horizontal counter wraps
   vga_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(i_en && w_h_last),
      .o_cnt(w_v_cnt), .o_last(w_v_last), .o_active(w_v_act), .o_sync_n(w_vs0));

   assign w_active      = w_h_act && w_v_act;
   assign o_x           = w_active ? w_h_cnt : '0;
   assign o_y           = w_active ? w_v_cnt[8:0] : '0;
   assign o_frame_start = (w_h_cnt == '0) && (w_v_cnt == '0) && i_en && !(w_v_last && w_h_last);
   assign o_vga_r       = r_rgb[23:16];
   assign o_vga_g       = r_rgb[15:8];
   assign o_vga_b       = r_rgb[7:0];
   assign o_vga_hs      = r_hs;
   assign o_vga_vs      = r_vs;
   assign o_vga_blank_n = r_blank_n;
   assign o_vga_sync_n  = 1'b0;

   // Colour, blank and syncs share one register stage so they stay aligned one clock behind the counters
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_rgb     <= '0;
         r_blank_n <= 1'b0;
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
      end else if (i_en) begin
         r_rgb     <= w_active ? i_rgb : '0;
         r_blank_n <= w_active;
         r_hs      <= w_hs0;
         r_vs      <= w_vs0;
      end
endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: full-size and shrunk-geometry DUTs checked every cycle against a position-arithmetic model
module tb_vga_ctrl;
   import vga_ctrl_pkg::*;

   typedef struct packed {
      logic [9:0]  x;
      logic [8:0]  y;
      logic        fs;
      logic [23:0] rgb;
      logic        bl;
      logic        hs;
      logic        vs;
      logic        sn;
   } obs_t;

   logic clk = 0, rst_n = 0, en = 0, pat = 0, stat_on = 0;
   always #5 clk = ~clk;

   logic [9:0]  x_f, x_s;
   logic [8:0]  y_f, y_s;
   logic [7:0]  r_f, g_f, b_f, r_s, g_s, b_s;
   logic        hs_f, vs_f, bl_f, sn_f, fs_f, hs_s, vs_s, bl_s, sn_s, fs_s;
   logic [23:0] rgb_f, rgb_s;

   // Frame lookup stand-in: constant colour or a colour encoding the requested pixel
   assign rgb_f = pat ? {5'd0, y_f, x_f} : 24'hFF8040;
   assign rgb_s = pat ? {5'd0, y_s, x_s} : 24'hFF8040;

   vga_ctrl u_full (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_x(x_f), .o_y(y_f), .i_rgb(rgb_f),
      .o_vga_r(r_f), .o_vga_g(g_f), .o_vga_b(b_f), .o_vga_hs(hs_f), .o_vga_vs(vs_f),
      .o_vga_blank_n(bl_f), .o_vga_sync_n(sn_f), .o_frame_start(fs_f));

   vga_ctrl #(.H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
              .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)) u_small (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .o_x(x_s), .o_y(y_s), .i_rgb(rgb_s),
      .o_vga_r(r_s), .o_vga_g(g_s), .o_vga_b(b_s), .o_vga_hs(hs_s), .o_vga_vs(vs_s),
      .o_vga_blank_n(bl_s), .o_vga_sync_n(sn_s), .o_frame_start(fs_s));

   int errors = 0, checks = 0;
   int ticks = 0, prev_tick = 0;
   bit fresh = 1, prev_pat = 0;

   // Model state: number of enabled clocks since reset, plus what was presented on the last one
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ticks = 0;
         fresh = 1;
      end else if (en) begin
         prev_tick = ticks;
         prev_pat  = pat;
         fresh     = 0;
         ticks++;
      end

   function automatic obs_t model(int ha, int hf, int hy, int hb, int va, int vf, int vy, int vb);
      obs_t o;
      int ht = ha + hf + hy + hb;
      int vt = va + vf + vy + vb;
      int h  = ticks % ht;
      int v  = (ticks / ht) % vt;
      int ph = prev_tick % ht;
      int pv = (prev_tick / ht) % vt;
      bit act = (ph < ha) && (pv < va);
      bit vis = (h < ha) && (v < va);
      o.x   = vis ? 10'(h) : 10'd0;
      o.y   = vis ? 9'(v) : 9'd0;
      o.fs  = (h == 0) && (v == 0) && en;
      o.rgb = (fresh || !act) ? 24'd0 : prev_pat ? {5'd0, 9'(pv), 10'(ph)} : 24'hFF8040;
      o.bl  = !fresh && act;
      o.hs  = fresh || !((ph >= ha + hf) && (ph < ha + hf + hy));
      o.vs  = fresh || !((pv >= va + vf) && (pv < va + vf + vy));
      o.sn  = 1'b0;
      return o;
   endfunction

   task automatic cmp(string name, obs_t got, obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   task automatic lit(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
      end
   endtask

   task automatic wait_pos(string name, int m, int t);
      int i = 0;
      while ((ticks % m) != t && i < 2000) begin
         @(negedge clk);
         i++;
      end
      checks++;
      if ((ticks % m) != t) begin
         errors++;
         $display("FAIL %s timeout got=%0d exp=%0d", name, ticks % m, t);
      end
   endtask

   // Every-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      cmp("full", {x_f, y_f, fs_f, r_f, g_f, b_f, bl_f, hs_f, vs_f, sn_f},
          model(H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP));
      cmp("small", {x_s, y_s, fs_s, r_s, g_s, b_s, bl_s, hs_s, vs_s, sn_s},
          model(10, 2, 3, 2, 6, 1, 2, 3));
   end

   int fs_cnt_s = 0, act_s = 0, vs_low_s = 0, runs_s = 0, bad_s = 0, cur_s = 0;
   int runs_f = 0, bad_f = 0, cur_f = 0, act_f = 0;

   // Aggregate frame statistics over the measurement window
   always @(negedge clk)
      if (stat_on) begin
         fs_cnt_s += int'(fs_s);
         act_s    += int'(bl_s && {r_s, g_s, b_s} == 24'hFF8040);
         act_f    += int'(bl_f && {r_f, g_f, b_f} == 24'hFF8040);
         vs_low_s += int'(!vs_s);
         if (!hs_s) cur_s++;
         else if (cur_s > 0) begin
            runs_s++;
            if (cur_s != 3) bad_s++;
            cur_s = 0;
         end
         if (!hs_f) cur_f++;
         else if (cur_f > 0) begin
            runs_f++;
            if (cur_f != 96) bad_f++;
            cur_f = 0;
         end
      end

   initial begin
      rst_n = 0;
      en    = 1;
      pat   = 0;
      repeat (3) @(negedge clk);
      lit("rst_hs", hs_f, 1);
      lit("rst_vs", vs_f, 1);
      lit("rst_blank", bl_f, 0);
      lit("rst_rgb", {r_f, g_f, b_f}, 0);
      lit("rst_x", x_f, 0);
      lit("rst_sync_n", sn_f, 0);
      #1 rst_n = 1;
      stat_on = 1;
      #1 lit("rel_fs", fs_f, 1);
      lit("rel_y", y_f, 0);
      repeat (2448) @(negedge clk);
      #1 stat_on = 0;
      lit("stat_fs_small", fs_cnt_s, 12);
      lit("stat_hs_runs_small", runs_s, 144);
      lit("stat_hs_badlen_small", bad_s, 0);
      lit("stat_active_small", act_s, 720);
      lit("stat_vs_low_small", vs_low_s, 408);
      lit("stat_hs_runs_full", runs_f, 3);
      lit("stat_hs_badlen_full", bad_f, 0);
      lit("stat_active_full", act_f, 1968);
      pat = 1;
      wait_pos("wait_h656", H_TOTAL, 656);
      lit("hs_before_fall", hs_f, 1);
      @(negedge clk);
      lit("hs_fall", hs_f, 0);
      wait_pos("wait_h640", H_TOTAL, 640);
      lit("blank_before_fall", bl_f, 1);
      @(negedge clk);
      lit("blank_fall", bl_f, 0);
      wait_pos("wait_h300", H_TOTAL, 300);
      lit("x_300", x_f, 300);
      #1 en = 0;
      repeat (37) @(negedge clk);
      lit("freeze_x", x_f, 300);
      lit("freeze_blank", bl_f, 1);
      #1 en = 1;
      @(negedge clk);
      lit("resume_x", x_f, 301);
      wait_pos("wait_h700", H_TOTAL, 700);
      lit("porch_x", x_f, 0);
      #1 rst_n = 0;
      #1 lit("midrst_hs", hs_f, 1);
      lit("midrst_vs", vs_f, 1);
      lit("midrst_blank", bl_f, 0);
      lit("midrst_rgb", {r_f, g_f, b_f}, 0);
      lit("midrst_blank_small", bl_s, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1;
      #1 lit("rerel_fs", fs_f, 1);
      lit("rerel_x", x_f, 0);
      lit("rerel_y", y_f, 0);
      wait_pos("wait_small_last", 204, 203);
      lit("small_last_fs", fs_s, 0);
      @(negedge clk);
      lit("small_wrap_fs", fs_s, 1);
      lit("small_wrap_y", y_s, 0);
      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
